if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues req/ack fetches to instruction memory and
//  presents {PC+4, instr, valid} to the IF/ID pipeline register directly downstream.
//  Absorbs ID-stage stalls via a 1-entry skid buffer and squashes wrong-path fetches on
//  branch/jump redirect, including fetches still outstanding in memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC / first fetch address after reset
//  NOP_INSTR  32'h0000_0000  value driven on instr__o whenever valid__o=0
// PORTS
//  clock__i        in   1   single clock, all state on rising edge
//  reset__i        in   1   asynchronous, active-high reset
//  stall__i        in   1   downstream hazard stall: output slot not consumed this cycle
//  redirect__i     in   1   taken branch/jump: discard all in-flight/held fetches
//  redirect_pc__i  in   32  redirect target; bits [1:0] ignored (treated as 00)
//  imem_req__o     out  1   fetch request
//  imem_addr__o    out  32  word-aligned fetch address, stable while req=1 and ack=0
//  imem_ack__i     in   1   response valid; only meaningful when imem_req__o=1
//  imem_rdata__i   in   32  instruction word, valid with imem_ack__i
//  PC_4__o         out  32  PC+4 of the presented instruction (registered)
//  instr__o        out  32  presented instruction (registered)
//  valid__o        out  1   presented instruction is real (not a bubble)
// BEHAVIOUR
//  Reset (async, any state): state=REQ, pc_q=addr_q=RESET_PC, valid__o=0, instr__o=NOP_INSTR,
//   PC_4__o=0, skid empty; imem_req__o forced 0 while reset__i=1.
//  Consume event: valid__o=1 && stall__i=0 at a rising edge -> output slot freed.
//  imem_addr__o = addr_q; a new request loads addr_q<=pc_q; addr_q never changes while
//   req=1 and ack=0.
//  States:
//   REQ  : req=1. On ack (no redirect): pc_q<=pc_q+4 (32-bit wrap; FFFF_FFFC -> 0).
//          Slot empty or consumed this edge -> load outputs {rdata, addr_q+4, valid=1},
//          stay REQ. Slot held (valid && stall) -> load skid, go FULL.
//          No ack: hold req/addr; outputs hold, or clear valid__o if consumed.
//   FULL : req=0. On consume: outputs<=skid, skid empty, go REQ with addr_q<=pc_q.
//   DROP : req=1 at old addr_q; all acks discarded. On ack -> REQ; next request uses pc_q.
//  Redirect (highest priority, overrides stall and ack): valid__o<=0, instr__o<=NOP_INSTR,
//   skid cleared, pc_q<={redirect_pc__i[31:2],2'b00}.
//   REQ with ack same cycle -> data dropped, stay REQ, next request at target.
//   REQ without ack -> DROP (outstanding request completes, data discarded).
//   FULL -> REQ at target. DROP -> stay DROP, pc_q retargeted (last redirect wins).
//  Latency: ack in cycle N -> valid__o/instr__o in cycle N+1. Zero-wait memory (ack same
//   cycle as req) sustains 1 instr/cycle with stall__i=0.
//  No instruction lost or duplicated across any stall pattern; order = program order.
//  Reset mid-request: outstanding fetch abandoned, no drain; memory must tolerate req drop.
// TESTING
//  1 Reset, zero-wait mem returning addr as data -> valid from cycle 2; PC_4__o=4,8,12...;
//    instr__o=0,4,8...
//  2 Stall 3 cycles while ack arrives -> skid fills, req=0 in FULL; after release outputs
//    present buffered then next instr, none lost/duplicated.
//  3 Mem ack delayed 3 cycles, redirect to 0x100 in cycle 1 -> req stays at old addr till
//    ack, data dropped, next req addr=0x100, valid__o=0 meanwhile.
//  4 Redirect + stall in same cycle with valid held -> valid__o=0 next cycle, next fetch
//    at target.
//  5 redirect_pc__i=0xFFFF_FFFE -> fetch addr 0xFFFF_FFFC; PC_4__o=0; next fetch addr 0.
//  6 Assert reset__i in FULL with skid loaded -> outputs 0/NOP immediately, refetch RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   imem_req__o    fetch request (fetch unit -> memory)
//   imem_addr__o   word-aligned fetch address, stable while a request waits for ack
//   imem_ack__i    response valid (memory -> fetch unit)
//   imem_rdata__i  instruction word, valid with imem_ack__i
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
  logic        imem_req__o;
  logic [31:0] imem_addr__o;
  logic        imem_ack__i;
  logic [31:0] imem_rdata__i;

  modport master (output imem_req__o, output imem_addr__o,
                  input  imem_ack__i, input  imem_rdata__i);
  modport slave  (input  imem_req__o, input  imem_addr__o,
                  output imem_ack__i, output imem_rdata__i);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, fetches over a req/ack memory bus and
// presents {PC+4, instr, valid} to the IF/ID register. A one-entry skid buffer
// absorbs a fetch that lands while the output slot is stalled; a redirect
// squashes presented/held data and any fetch still outstanding in memory.
// Ports:
//   clock__i, reset__i        clock, async active-high reset
//   stall__i                  output slot not consumed this cycle
//   redirect__i/redirect_pc__i taken branch/jump and its target (bits [1:0] ignored)
//   imem                      fetch bus (master side)
//   PC_4__o, instr__o, valid__o presented instruction, registered
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   clock__i,
  input  logic                   reset__i,
  input  logic                   stall__i,
  input  logic                   redirect__i,
  input  logic [31:0]            redirect_pc__i,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            PC_4__o,
  output logic [31:0]            instr__o,
  output logic                   valid__o
);

  // REQ: request in flight at addr_q. FULL: skid holds a fetch, no request.
  // DROP: old request still outstanding, its data will be thrown away.
  typedef enum logic [1:0] {S_REQ, S_FULL, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;        // next address to request
  logic [31:0] addr_q, addr_d;    // address of the request on the bus
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        ack, consume;
  logic [31:0] tgt, pc_inc, addr_inc;

  assign ack      = imem.imem_ack__i;
  assign consume  = valid_q & ~stall__i;
  assign tgt      = {redirect_pc__i[31:2], 2'b00};
  assign pc_inc   = pc_q + 32'd4;
  assign addr_inc = addr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    if (redirect__i) begin
      // Skid occupancy is implied by FULL, so leaving FULL empties it.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = tgt;
      case (state_q)
        S_REQ:   if (ack) addr_d = tgt;
                 else     state_d = S_DROP;
        S_FULL:  begin state_d = S_REQ; addr_d = tgt; end
        // An ack landing with the redirect retires the stale request, so the
        // next request can go straight to the new target.
        S_DROP:  if (ack) begin state_d = S_REQ; addr_d = tgt; end
        default: state_d = S_REQ;
      endcase
    end else begin
      if (consume) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      case (state_q)
        S_REQ: if (ack) begin
          pc_d   = pc_inc;
          addr_d = pc_inc;
          if (!valid_q || consume) begin
            instr_d = imem.imem_rdata__i;
            pc4_d   = addr_inc;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imem.imem_rdata__i;
            skid_pc4_d   = addr_inc;
            state_d      = S_FULL;
          end
        end
        S_FULL: if (consume) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          addr_d  = pc_q;
          state_d = S_REQ;
        end
        S_DROP: if (ack) begin
          addr_d  = pc_q;
          state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock__i or posedge reset__i) begin
    if (reset__i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      pc4_q        <= 32'h0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Request gated by reset so memory sees it drop immediately.
  assign imem.imem_req__o  = ~reset__i & (state_q != S_FULL);
  assign imem.imem_addr__o = addr_q;
  assign PC_4__o           = pc4_q;
  assign instr__o          = instr_q;
  assign valid__o          = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] pc4, instr;
  logic        valid;

  int errors = 0;
  int checks = 0;

  if_fetch_unit_if imem_bus();

  if_fetch_unit dut (
    .clock__i(clk), .reset__i(rst), .stall__i(stall), .redirect__i(redirect),
    .redirect_pc__i(rpc), .imem(imem_bus.master),
    .PC_4__o(pc4), .instr__o(instr), .valid__o(valid)
  );

  always #5 clk = ~clk;

  // Memory: returns the address as data after a per-request latency.
  int lat_fix = 0;   // >=0: fixed latency, <0: random up to lat_max
  int lat_max = 0;
  int cnt;
  function automatic int newlat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, lat_max));
  endfunction
  assign imem_bus.imem_ack__i   = imem_bus.imem_req__o && (cnt == 0);
  assign imem_bus.imem_rdata__i = imem_bus.imem_ack__i ? imem_bus.imem_addr__o : 32'hDEAD_BEEF;
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= newlat();
    else if (imem_bus.imem_req__o && imem_bus.imem_ack__i) cnt <= newlat();
    else if (imem_bus.imem_req__o && cnt > 0) cnt <= cnt - 1;
  end

  // Reference model: program-order stream; a consumed slot must be the next
  // address of the stream, a redirect restarts the stream at the target.
  logic [31:0] exp_pc = 32'h0;
  logic        c_cons, c_valid, c_req, c_ack;
  logic [31:0] c_ins, c_p4, c_exp, c_addr;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
  endtask

  // One clock: drive inputs, sample pre-edge state, advance the model.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect = r; rpc = t;
    #1;
    c_valid = valid; c_ins = instr; c_p4 = pc4;
    c_req = imem_bus.imem_req__o; c_ack = imem_bus.imem_ack__i; c_addr = imem_bus.imem_addr__o;
    c_cons = valid && !s;
    c_exp = exp_pc;
    if (c_cons) exp_pc = exp_pc + 32'd4;
    if (r) exp_pc = {t[31:2], 2'b00};
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h0 || imem_bus.imem_req__o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b i=%h p4=%h req=%b want 0/0/0/0", valid, instr, pc4, imem_bus.imem_req__o);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; exp_pc = 32'h0;
    #1;
    checks++;
    if (imem_bus.imem_req__o !== 1'b1 || imem_bus.imem_addr__o !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", imem_bus.imem_req__o, imem_bus.imem_addr__o);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    lat_fix = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (i >= 1) begin
        checks++;
        if (c_valid !== 1'b1) begin
          errors++; $display("FAIL stream_valid: cycle %0d got %b want 1", i, c_valid);
        end
      end
      if (c_cons) begin
        checks++;
        if (c_ins !== c_exp || c_p4 !== c_exp + 32'd4) begin
          errors++; $display("FAIL stream_data: got %h/%h want %h/%h", c_ins, c_p4, c_exp, c_exp + 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall_skid();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (i >= 1) begin
        checks++;
        if (c_req !== 1'b0) begin
          errors++; $display("FAIL skid_req: stall cycle %0d got req=%b want 0", i, c_req);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (c_cons) begin
        checks++;
        if (c_ins !== c_exp || c_p4 !== c_exp + 32'd4) begin
          errors++; $display("FAIL skid_data: got %h/%h want %h/%h", c_ins, c_p4, c_exp, c_exp + 32'd4);
        end
      end
    end
  endtask

  task automatic test_redirect_drop();
    bit seen = 0;
    int ncons = 0;
    lat_fix = 3;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (c_addr === 32'h100) seen = 1;
      else begin
        checks++;
        if (c_req !== 1'b1 || c_addr !== 32'h0 || c_valid !== 1'b0) begin
          errors++; $display("FAIL drop_hold: got req=%b addr=%h v=%b want 1/00000000/0", c_req, c_addr, c_valid);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL drop_retarget: got no request at 00000100 want one within 10 cycles");
    end
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (c_cons) begin
        ncons++; checks++;
        if (c_ins !== c_exp || c_p4 !== c_exp + 32'd4) begin
          errors++; $display("FAIL drop_data: got %h/%h want %h/%h", c_ins, c_p4, c_exp, c_exp + 32'd4);
        end
      end
    end
    checks++;
    if (ncons < 1) begin
      errors++; $display("FAIL drop_progress: got %0d consumed want >=1", ncons);
    end
  endtask

  task automatic test_redirect_stall();
    lat_fix = 0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h203);
    checks++;
    if (valid !== 1'b0 || instr !== 32'h0 || imem_bus.imem_req__o !== 1'b1 || imem_bus.imem_addr__o !== 32'h200) begin
      errors++;
      $display("FAIL redir_stall: got v=%b i=%h req=%b addr=%h want 0/0/1/00000200", valid, instr, imem_bus.imem_req__o, imem_bus.imem_addr__o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (c_cons) begin
        checks++;
        if (c_ins !== c_exp || c_p4 !== c_exp + 32'd4) begin
          errors++; $display("FAIL redir_stall_data: got %h/%h want %h/%h", c_ins, c_p4, c_exp, c_exp + 32'd4);
        end
      end
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    checks++;
    if (imem_bus.imem_addr__o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: got %h want fffffffc", imem_bus.imem_addr__o);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (valid !== 1'b1 || instr !== 32'hFFFF_FFFC || pc4 !== 32'h0 || imem_bus.imem_addr__o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_out: got v=%b i=%h p4=%h addr=%h want 1/fffffffc/0/0", valid, instr, pc4, imem_bus.imem_addr__o);
    end
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (c_ins !== c_exp || c_exp !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got %h want %h", c_ins, c_exp);
    end
  endtask

  task automatic test_reset_full();
    lat_fix = 0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (c_req !== 1'b0) begin
      errors++; $display("FAIL full_before_reset: got req=%b want 0", c_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || instr !== 32'h0 || pc4 !== 32'h0 || imem_bus.imem_req__o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_full: got v=%b i=%h p4=%h req=%b want 0/0/0/0", valid, instr, pc4, imem_bus.imem_req__o);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; stall = 1'b0; exp_pc = 32'h0;
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (c_req !== 1'b1 || c_addr !== 32'h0) begin
      errors++; $display("FAIL refetch: got req=%b addr=%h want 1/00000000", c_req, c_addr);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (!c_cons || c_ins !== 32'h0 || c_p4 !== 32'h4) begin
      errors++; $display("FAIL refetch_data: got cons=%b %h/%h want 1 00000000/00000004", c_cons, c_ins, c_p4);
    end
  endtask

  task automatic test_random();
    logic        pend = 0;
    logic [31:0] paddr = 0;
    int ncons = 0;
    lat_fix = -1; lat_max = 2;
    for (int i = 0; i < 600; i++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 4);
      t = $urandom;
      cycle(s, r, t);
      if (pend && c_req) begin
        checks++;
        if (c_addr !== paddr) begin
          errors++; $display("FAIL rnd_addr_stable: got %h want %h", c_addr, paddr);
        end
      end
      pend = c_req && !c_ack; paddr = c_addr;
      if (!c_valid) begin
        checks++;
        if (c_ins !== 32'h0) begin
          errors++; $display("FAIL rnd_bubble_nop: got %h want 00000000", c_ins);
        end
      end
      if (c_cons) begin
        ncons++; checks++;
        if (c_ins !== c_exp || c_p4 !== c_exp + 32'd4) begin
          errors++; $display("FAIL rnd_data: got %h/%h want %h/%h", c_ins, c_p4, c_exp, c_exp + 32'd4);
        end
      end
    end
    checks++;
    if (ncons < 100) begin
      errors++; $display("FAIL rnd_progress: got %0d consumed want >=100", ncons);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_drop();
    test_redirect_stall();
    test_wrap();
    test_reset_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
